// File: rtl/fft_iter_addr_gen.sv
// rtl/fft_iter_addr_gen.sv - layer/butterfly address generator for the iterative radix-2 in-place FFT
module fft_iter_addr_gen #(
  parameter int LAYERS      = 5,
  parameter int BUTTERFLYES = 16,
  parameter int LayWL       = 3,
  parameter int ButtWL      = 4,
  parameter int AddrWL      = 5
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              EN,
  input  logic              START,
  input  logic              ADDR_EN,
  input  logic              BUT_STROB,
  output logic              BUSY,
  output logic              DONE,
  output logic              LAST_BUT,
  output logic [LayWL-1:0]  LAYER,
  output logic [AddrWL-1:0] RD_ADDR_A,
  output logic [AddrWL-1:0] RD_ADDR_B,
  output logic [ButtWL-1:0] TW_ADDR,
  output logic [AddrWL-1:0] WR_ADDR_A,
  output logic [AddrWL-1:0] WR_ADDR_B
);

  typedef enum logic [1:0] {IDLE, RUN, FIN} state_t;

  localparam logic [LayWL-1:0]  S_LAST = LayWL'(LAYERS - 1);
  localparam logic [ButtWL-1:0] B_LAST = ButtWL'(BUTTERFLYES - 1);

  state_t             state_q;
  logic [LayWL-1:0]   s_q;
  logic [ButtWL-1:0]  b_q;
  logic               busy_q;
  logic               done_q;
  logic [AddrWL-1:0]  wr_a_q;
  logic [AddrWL-1:0]  wr_b_q;

  logic [AddrWL-1:0]  half;
  logic [ButtWL-1:0]  pos;
  logic [ButtWL-1:0]  grp;
  logic [LayWL-1:0]   sp1;
  logic [LayWL-1:0]   tw_sh;
  logic [AddrWL-1:0]  rd_a;
  logic [AddrWL-1:0]  rd_b;
  logic [ButtWL-1:0]  tw;
  logic               run;

  // Butterfly b of layer s pairs elements half apart inside groups of 2*half.
  always_comb begin
    half  = AddrWL'(1) << s_q;
    pos   = b_q & ButtWL'(half - AddrWL'(1));
    grp   = b_q >> s_q;
    sp1   = s_q + LayWL'(1);
    tw_sh = S_LAST - s_q;
    rd_a  = (AddrWL'(grp) << sp1) | AddrWL'(pos);
    rd_b  = rd_a + half;
    tw    = pos << tw_sh;
  end

  assign run       = (state_q == RUN);
  assign BUSY      = busy_q;
  assign DONE      = done_q;
  assign LAST_BUT  = run && (s_q == S_LAST) && (b_q == B_LAST);
  assign LAYER     = s_q;
  assign RD_ADDR_A = run ? rd_a : '0;
  assign RD_ADDR_B = run ? rd_b : '0;
  assign TW_ADDR   = run ? tw : '0;
  assign WR_ADDR_A = wr_a_q;
  assign WR_ADDR_B = wr_b_q;

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= IDLE;
      s_q     <= '0;
      b_q     <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      wr_a_q  <= '0;
      wr_b_q  <= '0;
    end else if (EN) begin
      case (state_q)
        IDLE: begin
          if (START) begin
            s_q     <= '0;
            b_q     <= '0;
            busy_q  <= 1'b1;
            state_q <= RUN;
          end
        end
        RUN: begin
          // Strobe samples the pre-advance addresses even when ADDR_EN is also high.
          if (BUT_STROB) begin
            wr_a_q <= rd_a;
            wr_b_q <= rd_b;
          end
          if (ADDR_EN) begin
            if (b_q != B_LAST) begin
              b_q <= b_q + ButtWL'(1);
            end else if (s_q != S_LAST) begin
              b_q <= '0;
              s_q <= s_q + LayWL'(1);
            end else begin
              b_q     <= '0;
              s_q     <= '0;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
              state_q <= FIN;
            end
          end
        end
        FIN: begin
          done_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: begin
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fft_iter_addr_gen.sv
// tb/tb_fft_iter_addr_gen.sv - self-checking bench for fft_iter_addr_gen
module tb_fft_iter_addr_gen;

  localparam int NL    = 5;
  localparam int NBF   = 16;
  localparam int LASTK = NL * NBF - 1;

  logic       CLK = 1'b0;
  logic       RST = 1'b1;
  logic       EN = 1'b0;
  logic       START = 1'b0;
  logic       ADDR_EN = 1'b0;
  logic       BUT_STROB = 1'b0;
  logic       BUSY, DONE, LAST_BUT;
  logic [2:0] LAYER;
  logic [4:0] RD_ADDR_A, RD_ADDR_B, WR_ADDR_A, WR_ADDR_B;
  logic [3:0] TW_ADDR;

  fft_iter_addr_gen dut (
    .CLK(CLK), .RST(RST), .EN(EN), .START(START), .ADDR_EN(ADDR_EN),
    .BUT_STROB(BUT_STROB), .BUSY(BUSY), .DONE(DONE), .LAST_BUT(LAST_BUT),
    .LAYER(LAYER), .RD_ADDR_A(RD_ADDR_A), .RD_ADDR_B(RD_ADDR_B),
    .TW_ADDR(TW_ADDR), .WR_ADDR_A(WR_ADDR_A), .WR_ADDR_B(WR_ADDR_B)
  );

  always #5 CLK = ~CLK;

  int errors = 0;
  int checks = 0;
  int done_cnt = 0;

  // Reference model: mode 0=idle 1=run 2=fin, k = ordinal of the current butterfly.
  int m_mode = 0;
  int m_k = 0;
  int m_wa = 0;
  int m_wb = 0;

  function automatic void model_addr(input int k, output int a, output int b, output int tw);
    int s, bb, half, pos, grp;
    s    = k / NBF;
    bb   = k % NBF;
    half = 2 ** s;
    pos  = bb % half;
    grp  = bb / half;
    a    = grp * 2 * half + pos;
    b    = a + half;
    tw   = (pos * (2 ** (NL - 1 - s))) % NBF;
  endfunction

  function automatic void model_step(input logic rst, input logic en, input logic st,
                                     input logic ae, input logic bs);
    int a, b, tw;
    if (rst) begin
      m_mode = 0; m_k = 0; m_wa = 0; m_wb = 0;
    end else if (en) begin
      case (m_mode)
        0: if (st) begin m_mode = 1; m_k = 0; end
        1: begin
          if (bs) begin
            model_addr(m_k, a, b, tw);
            m_wa = a; m_wb = b;
          end
          if (ae) begin
            if (m_k == LASTK) begin m_mode = 2; m_k = 0; end
            else m_k = m_k + 1;
          end
        end
        default: m_mode = 0;
      endcase
    end
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic check_model();
    int a, b, tw;
    if (m_mode == 1) model_addr(m_k, a, b, tw);
    else begin a = 0; b = 0; tw = 0; end
    chk("busy", int'(BUSY), int'(m_mode == 1));
    chk("done", int'(DONE), int'(m_mode == 2));
    chk("last_but", int'(LAST_BUT), int'(m_mode == 1 && m_k == LASTK));
    chk("layer", int'(LAYER), (m_mode == 1) ? m_k / NBF : 0);
    chk("rd_a", int'(RD_ADDR_A), a);
    chk("rd_b", int'(RD_ADDR_B), b);
    chk("tw", int'(TW_ADDR), tw);
    chk("wr_a", int'(WR_ADDR_A), m_wa);
    chk("wr_b", int'(WR_ADDR_B), m_wb);
  endtask

  task automatic tick(input logic rst, input logic en, input logic st,
                      input logic ae, input logic bs);
    RST = rst; EN = en; START = st; ADDR_EN = ae; BUT_STROB = bs;
    @(posedge CLK);
    model_step(rst, en, st, ae, bs);
    #1;
    check_model();
    if (DONE) done_cnt++;
  endtask

  task automatic advance_to(input int target);
    while (m_mode == 1 && m_k < target) tick(1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
  endtask

  typedef struct {
    logic rst, en, st, ae, bs;
    int   busy, done, layer, a, b, tw, wa, wb;
  } vec_t;

  vec_t vt[10];

  initial begin
    vt[0] = '{1,0,0,0,0, 0,0,0, 0,0,0, 0,0};
    vt[1] = '{1,1,0,0,0, 0,0,0, 0,0,0, 0,0};
    vt[2] = '{0,1,0,1,0, 0,0,0, 0,0,0, 0,0};
    vt[3] = '{0,1,0,1,1, 0,0,0, 0,0,0, 0,0};
    vt[4] = '{0,1,0,1,0, 0,0,0, 0,0,0, 0,0};
    vt[5] = '{0,1,1,0,0, 1,0,0, 0,1,0, 0,0};
    vt[6] = '{0,1,0,1,0, 1,0,0, 2,3,0, 0,0};
    vt[7] = '{0,1,0,1,1, 1,0,0, 4,5,0, 2,3};
    vt[8] = '{0,0,0,1,0, 1,0,0, 4,5,0, 2,3};
    vt[9] = '{0,1,0,0,0, 1,0,0, 4,5,0, 2,3};

    for (int i = 0; i < 10; i++) begin
      tick(vt[i].rst, vt[i].en, vt[i].st, vt[i].ae, vt[i].bs);
      chk($sformatf("v%0d_busy", i), int'(BUSY), vt[i].busy);
      chk($sformatf("v%0d_done", i), int'(DONE), vt[i].done);
      chk($sformatf("v%0d_layer", i), int'(LAYER), vt[i].layer);
      chk($sformatf("v%0d_rd_a", i), int'(RD_ADDR_A), vt[i].a);
      chk($sformatf("v%0d_rd_b", i), int'(RD_ADDR_B), vt[i].b);
      chk($sformatf("v%0d_tw", i), int'(TW_ADDR), vt[i].tw);
      chk($sformatf("v%0d_wr_a", i), int'(WR_ADDR_A), vt[i].wa);
      chk($sformatf("v%0d_wr_b", i), int'(WR_ADDR_B), vt[i].wb);
    end

    // Mid-layer addressing, write capture and EN freeze
    advance_to(1 * NBF + 3);
    chk("s1b3_a", int'(RD_ADDR_A), 5);
    chk("s1b3_b", int'(RD_ADDR_B), 7);
    chk("s1b3_tw", int'(TW_ADDR), 8);
    tick(1'b0, 1'b1, 1'b0, 1'b1, 1'b1);
    chk("cap_wr_a", int'(WR_ADDR_A), 5);
    chk("cap_wr_b", int'(WR_ADDR_B), 7);
    repeat (4) tick(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    chk("frz_layer", int'(LAYER), 1);
    chk("frz_a", int'(RD_ADDR_A), 8);
    chk("frz_b", int'(RD_ADDR_B), 10);
    advance_to(2 * NBF + 6);
    chk("s2b6_a", int'(RD_ADDR_A), 10);
    chk("s2b6_b", int'(RD_ADDR_B), 14);
    chk("s2b6_tw", int'(TW_ADDR), 8);
    advance_to(4 * NBF + 5);
    chk("s4b5_a", int'(RD_ADDR_A), 5);
    chk("s4b5_b", int'(RD_ADDR_B), 21);
    chk("s4b5_tw", int'(TW_ADDR), 5);
    advance_to(LASTK);
    chk("last_but_hi", int'(LAST_BUT), 1);
    tick(1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
    chk("fin_done", int'(DONE), 1);
    chk("fin_busy", int'(BUSY), 0);
    chk("fin_wr_b_kept", int'(WR_ADDR_B), 7);
    tick(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    chk("idle_done", int'(DONE), 0);

    // Clean full run: 80 pulses, exactly one DONE cycle
    done_cnt = 0;
    tick(1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < NL * NBF; i++) begin
      if (i == NL * NBF - 1) chk("full_last_but", int'(LAST_BUT), 1);
      tick(1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
    end
    repeat (3) tick(1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
    chk("full_done_cnt", done_cnt, 1);
    chk("full_busy", int'(BUSY), 0);

    // Reset mid-operation, then reset vs START priority
    tick(1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    while (m_mode == 1 && m_k < 3 * NBF + 9) tick(1'b0, 1'b1, 1'b0, 1'b1, 1'b1);
    chk("pre_rst_layer", int'(LAYER), 3);
    done_cnt = 0;
    tick(1'b1, 1'b1, 1'b0, 1'b1, 1'b1);
    chk("rst_busy", int'(BUSY), 0);
    chk("rst_layer", int'(LAYER), 0);
    chk("rst_wr_a", int'(WR_ADDR_A), 0);
    chk("rst_wr_b", int'(WR_ADDR_B), 0);
    tick(1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    chk("rst_start_busy", int'(BUSY), 0);
    tick(1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    chk("restart_a", int'(RD_ADDR_A), 0);
    chk("restart_b", int'(RD_ADDR_B), 1);
    chk("rst_no_done", done_cnt, 0);

    // Randomised traffic against the model
    repeat (4000) begin
      tick(($urandom % 512) == 0, ($urandom % 10) < 8, ($urandom % 8) == 0,
           ($urandom % 2) == 0, ($urandom % 10) < 3);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/fft_iter_addr_gen.md
Name: fft_iter_addr_gen

Overview:
Address generator for the iterative radix-2 in-place FFT core. It sits directly downstream of the iterative FFT control unit and consumes its START, ADDR_EN, BUT_STROB and EN signals. It tracks the layer and butterfly indices and produces the dual-port RAM read addresses, the twiddle ROM address, and the latched write-back addresses for each butterfly. It also reports run status to the top level.

Parameters:
LAYERS, 5, number of FFT layers (log2 N); N = 2^LAYERS points
BUTTERFLYES, 16, butterflies per layer (N/2)
LayWL, 3, layer counter width (holds 0..LAYERS-1)
ButtWL, 4, butterfly counter width and twiddle address width (log2 BUTTERFLYES)
AddrWL, 5, data RAM address width (ButtWL+1)

Ports:
CLK  in  1  clock
RST  in  1  synchronous reset, active-high
EN  in  1  global clock enable; when low, all state is frozen
START  in  1  starts a transform; accepted only in IDLE
ADDR_EN  in  1  advance to the next butterfly (pulse from the control unit)
BUT_STROB  in  1  captures the current read addresses as the write-back addresses
BUSY  out  1  high in RUN
DONE  out  1  one-cycle pulse when the transform finishes
LAST_BUT  out  1  high while the indices point at the final butterfly of the final layer
LAYER  out  LayWL  current layer index s
RD_ADDR_A  out  AddrWL  upper butterfly input address
RD_ADDR_B  out  AddrWL  lower butterfly input address
TW_ADDR  out  ButtWL  twiddle ROM index
WR_ADDR_A  out  AddrWL  write-back address for the upper output
WR_ADDR_B  out  AddrWL  write-back address for the lower output

Behaviour:
- Clock and reset: one clock, CLK. Reset RST is synchronous and active-high.
- Reset values: state=IDLE. Layer counter s=0, butterfly counter b=0. BUSY=0, DONE=0, LAST_BUT=0. All address outputs read 0.
- EN=0: no register changes, including the FSM, counters and write-address registers. DONE holds its current value.
- FSM states: IDLE, RUN, FIN.
  - IDLE: on EN&START, set s=0 and b=0, then go to RUN. ADDR_EN and BUT_STROB are ignored in IDLE.
  - RUN: on EN&ADDR_EN:
    - if b<BUTTERFLYES-1, then b<=b+1;
    - else if s<LAYERS-1, then b<=0 and s<=s+1;
    - else go to FIN, with b and s cleared to 0.
    - START is ignored in RUN.
  - FIN: DONE=1 for exactly one EN-qualified cycle, then go to IDLE.
- BUSY = (state==RUN), registered through the state register.
- Address arithmetic is combinational from the registered s and b:
  - half = 2^s; pos = b & (half-1); grp = b >> s.
  - RD_ADDR_A = (grp << (s+1)) | pos.
  - RD_ADDR_B = RD_ADDR_A + half. This never overflows AddrWL.
  - TW_ADDR = pos << (LAYERS-1-s), truncated to ButtWL.
- Address outputs are 0 in IDLE and FIN.
- Latency: the addresses for the next butterfly appear the cycle after the accepted ADDR_EN.
- LAST_BUT = RUN & s==LAYERS-1 & b==BUTTERFLYES-1.
- LAYER output = s.
- Write-back registers: on EN&BUT_STROB in RUN, WR_ADDR_A<=RD_ADDR_A and WR_ADDR_B<=RD_ADDR_B. They hold until the next strobe. They are not cleared on FIN, so the final write can complete.
- Simultaneous ADDR_EN and BUT_STROB in one cycle: the strobe captures the pre-advance addresses.
- RST mid-RUN: return to IDLE immediately and clear all registers, including WR_ADDR_A/B.
- START and RST in the same cycle: reset wins.

Test Plan:
1. Reset/idle: assert RST for 2 cycles, then pulse ADDR_EN ×3 without START -> BUSY=0, LAYER=0, RD_ADDR_A=0, WR_ADDR_A=0 throughout.
2. Layer 0 start: START, then check -> BUSY=1, RD_ADDR_A=0, RD_ADDR_B=1, TW_ADDR=0. After 1 ADDR_EN -> A=2, B=3, TW=0.
3. Mid-layer addressing:
   - advance to s=1, b=3 -> A=5, B=7, TW=8;
   - advance to s=2, b=6 -> A=10, B=14, TW=8;
   - advance to s=4, b=5 -> A=5, B=21, TW=5.
4. Full run: 80 accepted ADDR_EN pulses -> LAST_BUT=1 before the 80th pulse; FIN follows; DONE=1 for one cycle; then IDLE with BUSY=0. Total DONE count is 1.
5. Write capture and EN freeze:
   - at s=1, b=3, assert BUT_STROB together with ADDR_EN -> WR_ADDR_A=5, WR_ADDR_B=7;
   - hold EN=0 for 4 cycles with ADDR_EN high -> indices and outputs unchanged.
6. Reset mid-operation: at s=3, b=9, assert RST -> next cycle IDLE, s=0, b=0, WR_ADDR_A/B=0, no DONE pulse. A new START restarts at A=0, B=1.
